// File: rtl/field_unpacker.sv
// field_unpacker: receive-side stream unpacker. Takes one packed word
// {fN-1,...,f1,f0} per input handshake and replays its fields one per output
// handshake, f0 first, tagged with the field index and a last flag. The last
// field's handshake can accept the next word in the same cycle, so a
// continuously ready consumer sees one field per cycle with no bubble.
module field_unpacker #(
    parameter  int FIELD_W    = 1,
    parameter  int NUM_FIELDS = 3,
    localparam int IDX_W      = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [FIELD_W*NUM_FIELDS-1:0] in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [FIELD_W-1:0]            out_data,
    output logic [IDX_W-1:0]              out_idx,
    output logic                          out_last,
    output logic                          out_valid,
    input  logic                          out_ready
);

    localparam int                    WORD_W   = FIELD_W * NUM_FIELDS;
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_FIELDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   hold_q,  hold_d;
    logic [IDX_W-1:0]    idx_q,   idx_d;

    logic                is_last;
    logic                accept;
    logic                emit;

    // State, held word and field index; reset discards any partially emitted word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
        end
    end

    // Next state: step through fields, reload on accept, fall back to IDLE when drained.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    hold_d  = in_data;
                    idx_d   = '0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (emit) begin
                    if (!is_last) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else if (accept) begin
                        // Last field leaves as the next word arrives: no bubble.
                        hold_d = in_data;
                        idx_d  = '0;
                    end else begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    // Handshake outputs; in_ready looks through out_ready only on the last field.
    always_comb begin
        is_last   = (idx_q == LAST_IDX);
        out_valid = (state_q == EMIT);
        out_last  = out_valid & is_last;
        out_idx   = idx_q;
        in_ready  = (state_q == IDLE) | (out_last & out_ready);
        accept    = in_valid & in_ready;
        emit      = out_valid & out_ready;
    end

    // Field select: registered word muxed by registered index, no reordering or extension.
    always_comb begin
        out_data = '0;
        for (int k = 0; k < NUM_FIELDS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                out_data = hold_q[k*FIELD_W +: FIELD_W];
            end
        end
    end

endmodule
